// File: rtl/otg_hpi_bus_sequencer_if.sv
// Request/response handshake plus HPI pad signals for the HPI bus sequencer.
// The sequencer uses the slave modport; the CPU-side/pad-side environment uses master.
interface otg_hpi_bus_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n;
  logic        hpi_rd_n;
  logic        hpi_wr_n;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_in;

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  hpi_data_in,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output hpi_addr,
    output hpi_cs_n,
    output hpi_rd_n,
    output hpi_wr_n,
    output hpi_data_out,
    output hpi_data_oe
  );

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output hpi_data_in,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  hpi_addr,
    input  hpi_cs_n,
    input  hpi_rd_n,
    input  hpi_wr_n,
    input  hpi_data_out,
    input  hpi_data_oe
  );
endinterface

// File: rtl/otg_hpi_bus_sequencer.sv
// Turns one CPU-side request into a timed EZ-OTG HPI bus cycle
// (setup / strobe / hold / recovery) with registered, glitch-free pad outputs.
module otg_hpi_bus_sequencer #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2
) (
  input logic                      clk,
  input logic                      reset_n,
  otg_hpi_bus_sequencer_if.slave   bus_io
);

  if (SETUP_CYC == 0 || STROBE_CYC == 0 || HOLD_CYC == 0 || RECOVER_CYC == 0) begin : g_param_err
    $error("otg_hpi_bus_sequencer: every timing parameter must be at least 1");
  end

  localparam int unsigned MaxA   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MaxB   = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] SetupLd   = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StrobeLd  = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] HoldLd    = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] RecoverLd = CntW'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              lat_write_q, lat_write_d;
  logic [1:0]        lat_addr_q, lat_addr_d;
  logic [15:0]       lat_wdata_q, lat_wdata_d;

  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              oe_q, oe_d;
  logic [1:0]        hpi_addr_q, hpi_addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rdata_q, rdata_d;

  logic              ready;
  logic              accept;

  // The last RECOVER cycle already advertises ready so a back-to-back request
  // is accepted on the very edge that ends recovery.
  always_comb begin
    ready = (state_q == StIdle) || ((state_q == StRecover) && (cnt_q == '0));
  end

  assign accept           = bus_io.req_valid && ready;
  assign bus_io.req_ready = ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Next-state logic; the down-counter is reloaded on every state entry
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StRecover;
          cnt_d   = RecoverLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRecover: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      state_d     = StSetup;
      cnt_d       = SetupLd;
      lat_write_d = bus_io.req_write;
      lat_addr_d  = bus_io.req_addr;
      lat_wdata_d = bus_io.req_wdata;
    end
  end

  // Output logic, decoded from the next state so the pad flops switch together with the FSM
  always_comb begin
    cs_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    oe_d        = 1'b0;
    hpi_addr_d  = hpi_addr_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_d)
      StSetup, StHold: begin
        cs_n_d     = 1'b0;
        hpi_addr_d = lat_addr_d;
        dout_d     = lat_wdata_d;
        oe_d       = lat_write_d;
      end
      StStrobe: begin
        cs_n_d     = 1'b0;
        hpi_addr_d = lat_addr_d;
        dout_d     = lat_wdata_d;
        oe_d       = lat_write_d;
        rd_n_d     = lat_write_d;
        wr_n_d     = !lat_write_d;
      end
      StRecover: begin
        rsp_valid_d = (state_q == StHold);
      end
      default: ;
    endcase

    if ((state_q == StStrobe) && (state_d == StHold) && !lat_write_q) begin
      rdata_d = bus_io.hpi_data_in;
    end
  end

  // Registered pad and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      hpi_addr_q  <= '0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      oe_q        <= oe_d;
      hpi_addr_q  <= hpi_addr_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_io.hpi_cs_n     = cs_n_q;
  assign bus_io.hpi_rd_n     = rd_n_q;
  assign bus_io.hpi_wr_n     = wr_n_q;
  assign bus_io.hpi_data_oe  = oe_q;
  assign bus_io.hpi_addr     = hpi_addr_q;
  assign bus_io.hpi_data_out = dout_q;
  assign bus_io.rsp_valid    = rsp_valid_q;
  assign bus_io.rsp_rdata    = rdata_q;

  a_no_contention: assert property (@(posedge clk) disable iff (!reset_n)
    !(oe_q && !rd_n_q));
  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(!rd_n_q && !wr_n_q));

endmodule
